// File: rtl/reg_sel_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_sel_if
// Brief    : Request/strobe bundle shared by reg_sel_sequencer and its driver.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_sel_if #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 4,
    parameter int CNT_W    = 4
) ();
    logic                enable;
    logic                req_valid;
    logic                req_ready;
    logic [IDX_W-1:0]    req_idx;
    logic [CNT_W-1:0]    req_cnt;
    logic [NUM_REGS-1:0] r_sig;
    logic                busy;
    logic                done;

    modport master (
        output enable,
        output req_valid,
        output req_idx,
        output req_cnt,
        input  req_ready,
        input  r_sig,
        input  busy,
        input  done
    );

    modport slave (
        input  enable,
        input  req_valid,
        input  req_idx,
        input  req_cnt,
        output req_ready,
        output r_sig,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/reg_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_sel_sequencer
// Brief    : Issues a burst of registered one-hot register-select strobes
//            starting at a requested index, wrapping at NUM_REGS.
//            Optional macro REG_SEL_ERR_EN adds a sticky out-of-range flag.
// Revision : 1.0 - initial release
// ============================================================================
module reg_sel_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 4,
    parameter int CNT_W    = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    reg_sel_if.slave   bus
`ifdef REG_SEL_ERR_EN
    ,
    output logic       err
`endif
);

    localparam logic [0:0]       ST_IDLE    = 1'b0;
    localparam logic [0:0]       ST_BURST   = 1'b1;
    localparam logic [31:0]      c_NUM_REGS = 32'(NUM_REGS);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_REGS - 1);

    logic [0:0]          r_state;
    logic [IDX_W-1:0]    r_cur_idx;
    logic [CNT_W-1:0]    r_remaining;
    logic [NUM_REGS-1:0] r_strobe;
    logic                r_done;

    logic [0:0]          w_state_nxt;
    logic [IDX_W-1:0]    w_cur_idx_nxt;
    logic [CNT_W-1:0]    w_remaining_nxt;
    logic [NUM_REGS-1:0] w_strobe_nxt;
    logic                w_done_nxt;
    logic [NUM_REGS-1:0] w_onehot;
    logic [31:0]         w_idx_ext;
    logic                w_idx_ok;

`ifdef REG_SEL_ERR_EN
    logic                r_err;
    logic                w_err_nxt;
`endif

    // Compare at 32 bits so NUM_REGS == 2^IDX_W does not truncate to zero.
    assign w_idx_ext = 32'(bus.req_idx);
    assign w_idx_ok  = (w_idx_ext < c_NUM_REGS);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_onehot
        assign w_onehot[g] = (r_cur_idx == IDX_W'(g));
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_idx_nxt   = r_cur_idx;
        w_remaining_nxt = r_remaining;
        w_strobe_nxt    = '0;
        w_done_nxt      = 1'b0;
`ifdef REG_SEL_ERR_EN
        w_err_nxt       = r_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (w_idx_ok) begin
                        w_cur_idx_nxt   = bus.req_idx;
                        w_remaining_nxt = bus.req_cnt;
                        w_state_nxt     = ST_BURST;
                    end else begin
`ifdef REG_SEL_ERR_EN
                        w_err_nxt = 1'b1;
`endif
                    end
                end
            end
            ST_BURST: begin
                // enable low freezes the burst and blanks the strobe
                if (bus.enable) begin
                    w_strobe_nxt  = w_onehot;
                    w_cur_idx_nxt = (r_cur_idx == c_LAST_IDX) ? '0 : r_cur_idx + 1'b1;
                    if (r_remaining == '0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_remaining_nxt = r_remaining - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cur_idx   <= '0;
            r_remaining <= '0;
            r_strobe    <= '0;
            r_done      <= 1'b0;
`ifdef REG_SEL_ERR_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cur_idx   <= w_cur_idx_nxt;
            r_remaining <= w_remaining_nxt;
            r_strobe    <= w_strobe_nxt;
            r_done      <= w_done_nxt;
`ifdef REG_SEL_ERR_EN
            r_err       <= w_err_nxt;
`endif
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state == ST_BURST);
    assign bus.r_sig     = r_strobe;
    assign bus.done      = r_done;
`ifdef REG_SEL_ERR_EN
    assign err           = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_sel_sequencer
// Brief    : Directed and random stimulus against a queue-based strobe model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_sel_sequencer;
    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_sel_if #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();
`ifdef REG_SEL_ERR_EN
    logic err;
`endif

    reg_sel_sequencer #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef REG_SEL_ERR_EN
        ,
        .err (err)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Model: the strobes still owed by the current burst, in issue order.
    logic [NUM_REGS-1:0] pend [$];
    logic [NUM_REGS-1:0] exp_sig;
    logic                exp_done;
    logic                err_m;

    function automatic logic [NUM_REGS-1:0] onehot(input int i);
        logic [NUM_REGS-1:0] v;
        v = '0;
        v[i % NUM_REGS] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic v, input int idx, input int cnt, input logic r);
        bus.enable    = en;
        bus.req_valid = v;
        bus.req_idx   = IDX_W'(idx);
        bus.req_cnt   = CNT_W'(cnt);
        rst           = r;
        if (r) begin
            pend.delete();
            exp_sig  = '0;
            exp_done = 1'b0;
            err_m    = 1'b0;
        end else if (pend.size() == 0) begin
            exp_sig  = '0;
            exp_done = 1'b0;
            if (v) begin
                if (idx < NUM_REGS) begin
                    for (int k = 0; k <= cnt; k++) pend.push_back(onehot(idx + k));
                end else begin
                    err_m = 1'b1;
                end
            end
        end else if (en) begin
            exp_sig  = pend.pop_front();
            exp_done = (pend.size() == 0);
        end else begin
            exp_sig  = '0;
            exp_done = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("r_sig", 32'(bus.r_sig), 32'(exp_sig));
        chk("done", 32'(bus.done), 32'(exp_done));
        chk("busy", 32'(bus.busy), 32'(pend.size() != 0));
        chk("req_ready", 32'(bus.req_ready), 32'(pend.size() == 0));
`ifdef REG_SEL_ERR_EN
        chk("err", 32'(err), 32'(err_m));
`endif
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_idx   = '0;
        bus.req_cnt   = '0;
        rst           = 1'b1;
        err_m         = 1'b0;

        // reset state
        step(1, 0, 0, 0, 1);
        chk("reset_sig", 32'(bus.r_sig), 32'h0);
        chk("reset_ready", 32'(bus.req_ready), 32'h1);

        // single strobe at idx 3
        step(1, 1, 3, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("single_sig", 32'(bus.r_sig), 32'h08);
        chk("single_done", 32'(bus.done), 32'h1);
        step(1, 0, 0, 0, 0);

        // wrapping burst from idx 6
        step(1, 1, 6, 3, 0);
        step(1, 0, 0, 0, 0); chk("wrap_s0", 32'(bus.r_sig), 32'h40);
        step(1, 0, 0, 0, 0); chk("wrap_s1", 32'(bus.r_sig), 32'h80);
        step(1, 0, 0, 0, 0); chk("wrap_s2", 32'(bus.r_sig), 32'h01);
        step(1, 0, 0, 0, 0); chk("wrap_s3", 32'(bus.r_sig), 32'h02);
        chk("wrap_done", 32'(bus.done), 32'h1);
        step(1, 0, 0, 0, 0);

        // enable gaps inside a burst
        step(1, 1, 0, 4, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);

        // out-of-range request, then a valid one
        step(1, 1, 9, 2, 0);
        step(1, 0, 0, 0, 0);
        chk("oor_ready", 32'(bus.req_ready), 32'h1);
        step(1, 1, 2, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

        // reset mid-burst, then immediate new request
        step(1, 1, 1, 7, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        step(1, 1, 5, 1, 0);
        chk("reaccept_busy", 32'(bus.busy), 32'h1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

        // req_valid held with changing idx across a full-length burst
        step(1, 1, 4, 15, 0);
        for (int i = 0; i < 20; i++) step(1, 1, i % NUM_REGS, 1, 0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 59) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
